// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM states, datapath select codes and the decoded instruction class.
package mips_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    // R-type functs (instr[5:0])
    localparam logic [5:0] FunctAddu = 6'b100001;
    localparam logic [5:0] FunctSubu = 6'b100011;

    typedef enum logic [2:0] {
        StFetch = 3'd0,
        StDcd   = 3'd1,
        StExe   = 3'd2,
        StMem   = 3'd3,
        StAluWb = 3'd4,
        StMemWb = 3'd5,
        StTrap  = 3'd7
    } state_e;

    localparam logic [1:0] ExtZero = 2'b00;
    localparam logic [1:0] ExtSign = 2'b01;
    localparam logic [1:0] ExtHigh = 2'b10;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluOr  = 3'b010;

    localparam logic [1:0] NpcPlus4  = 2'b00;
    localparam logic [1:0] NpcBranch = 2'b01;
    localparam logic [1:0] NpcJump   = 2'b10;

    localparam logic [1:0] GprRd = 2'b00;
    localparam logic [1:0] GprRt = 2'b01;
    localparam logic [1:0] GprRa = 2'b10;

    localparam logic [1:0] WdAlu = 2'b00;
    localparam logic [1:0] WdMem = 2'b01;
    localparam logic [1:0] WdPc4 = 2'b10;

    // One-hot instruction class; exactly one field is set for any Op/Funct.
    typedef struct packed {
        logic rtype_add;
        logic rtype_sub;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic bad;
    } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational Op/Funct decode into a one-hot instruction class.
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output iclass_t    iclass_o
);

    // Unsupported opcodes and unsupported R-type functs both land in bad.
    always_comb begin
        iclass_o = '0;
        case (op_i)
            OpRtype: begin
                case (funct_i)
                    FunctAddu: iclass_o.rtype_add = 1'b1;
                    FunctSubu: iclass_o.rtype_sub = 1'b1;
                    default:   iclass_o.bad       = 1'b1;
                endcase
            end
            OpOri:   iclass_o.ori = 1'b1;
            OpLui:   iclass_o.lui = 1'b1;
            OpLw:    iclass_o.lw  = 1'b1;
            OpSw:    iclass_o.sw  = 1'b1;
            OpBeq:   iclass_o.beq = 1'b1;
            OpJ:     iclass_o.j   = 1'b1;
            OpJal:   iclass_o.jal = 1'b1;
            default: iclass_o.bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle main controller: sequences FETCH/DCD/EXE/MEM/WB and decodes
// every datapath enable and mux select from the current state and class.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] EXTOp,
    output logic [2:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic       BSel,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       illegal,
    output logic [2:0] state
);

    iclass_t ic;
    state_e  state_q, state_d;
    logic    rtype;

    ctrl_decode u_decode (
        .op_i     (Op),
        .funct_i  (Funct),
        .iclass_o (ic)
    );

    assign rtype   = ic.rtype_add | ic.rtype_sub;
    assign state   = state_q;
    // TRAP is absorbing until reset, so the flag is sticky by construction.
    assign illegal = (state_q == StTrap);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode of the registered state.
    always_comb begin
        state_d = StFetch;
        PCWr    = 1'b0;
        IRWr    = 1'b0;
        RFWr    = 1'b0;
        DMWr    = 1'b0;
        EXTOp   = ExtZero;
        ALUOp   = AluAdd;
        NPCOp   = NpcPlus4;
        BSel    = 1'b0;
        GPRSel  = GprRd;
        WDSel   = WdAlu;
        case (state_q)
            StFetch: begin
                PCWr    = 1'b1;
                IRWr    = 1'b1;
                state_d = StDcd;
            end
            StDcd: begin
                if (ic.j || ic.jal) begin
                    PCWr    = 1'b1;
                    NPCOp   = NpcJump;
                    state_d = StFetch;
                    if (ic.jal) begin
                        RFWr   = 1'b1;
                        GPRSel = GprRa;
                        WDSel  = WdPc4;
                    end
                end else if (ic.bad) begin
                    state_d = StTrap;
                end else begin
                    state_d = StExe;
                end
            end
            StExe: begin
                if (ic.beq) begin
                    ALUOp   = AluSub;
                    EXTOp   = ExtSign;
                    NPCOp   = NpcBranch;
                    PCWr    = Zero;
                    state_d = StFetch;
                end else if (ic.lw || ic.sw) begin
                    BSel    = 1'b1;
                    EXTOp   = ExtSign;
                    state_d = StMem;
                end else begin
                    if (ic.ori || ic.lui) begin
                        ALUOp = AluOr;
                        BSel  = 1'b1;
                        EXTOp = ic.lui ? ExtHigh : ExtZero;
                    end else if (ic.rtype_sub) begin
                        ALUOp = AluSub;
                    end
                    state_d = StAluWb;
                end
            end
            StMem: begin
                if (ic.sw) begin
                    DMWr    = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StMemWb;
                end
            end
            StAluWb: begin
                RFWr    = 1'b1;
                GPRSel  = rtype ? GprRd : GprRt;
                state_d = StFetch;
            end
            StMemWb: begin
                RFWr    = 1'b1;
                WDSel   = WdMem;
                GPRSel  = GprRt;
                state_d = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: the driver walks each instruction
// through its expected per-cycle outputs and queues them; the monitor pops
// and compares against the DUT once per cycle on the falling edge.
module tb_mips_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWr, IRWr, RFWr, DMWr, BSel, illegal;
    logic [1:0] EXTOp, NPCOp, GPRSel, WDSel;
    logic [2:0] ALUOp, state;

    mips_mc_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .Op      (Op),
        .Funct   (Funct),
        .Zero    (Zero),
        .PCWr    (PCWr),
        .IRWr    (IRWr),
        .RFWr    (RFWr),
        .DMWr    (DMWr),
        .EXTOp   (EXTOp),
        .ALUOp   (ALUOp),
        .NPCOp   (NPCOp),
        .BSel    (BSel),
        .GPRSel  (GPRSel),
        .WDSel   (WDSel),
        .illegal (illegal),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr;
        logic       irwr;
        logic       rfwr;
        logic       dmwr;
        logic [1:0] extop;
        logic [2:0] aluop;
        logic [1:0] npcop;
        logic       bsel;
        logic [1:0] gprsel;
        logic [1:0] wdsel;
        logic       ill;
    } exp_t;

    typedef enum int {KAddu, KSubu, KOri, KLui, KLw, KSw, KBeq, KJ, KJal, KBad} kind_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    // Cycles per instruction; an illegal one spends trap_len cycles in TRAP.
    function automatic int cpi(input kind_t k, input int trap_len);
        case (k)
            KJ, KJal: return 2;
            KBeq:     return 3;
            KLw:      return 5;
            KBad:     return 2 + trap_len;
            default:  return 4;
        endcase
    endfunction

    // Expected outputs in cycle ph of instruction k (ph 0 = fetch).
    function automatic exp_t model(input kind_t k, input int ph, input logic z);
        exp_t r;
        r = '0;
        if (ph == 0) begin
            r.st = 3'd0; r.pcwr = 1'b1; r.irwr = 1'b1;
        end else if (ph == 1) begin
            r.st = 3'd1;
            if (k == KJ || k == KJal) begin
                r.pcwr = 1'b1; r.npcop = 2'b10;
            end
            if (k == KJal) begin
                r.rfwr = 1'b1; r.gprsel = 2'b10; r.wdsel = 2'b10;
            end
        end else if (k == KBad) begin
            r.st = 3'd7; r.ill = 1'b1;
        end else if (ph == 2) begin
            r.st = 3'd2;
            case (k)
                KBeq: begin
                    r.aluop = 3'b001; r.extop = 2'b01; r.npcop = 2'b01; r.pcwr = z;
                end
                KSubu:    r.aluop = 3'b001;
                KOri:     begin r.aluop = 3'b010; r.bsel = 1'b1; end
                KLui:     begin r.aluop = 3'b010; r.bsel = 1'b1; r.extop = 2'b10; end
                KLw, KSw: begin r.bsel = 1'b1; r.extop = 2'b01; end
                default:  ;
            endcase
        end else if (ph == 3) begin
            if (k == KLw || k == KSw) begin
                r.st = 3'd3; r.dmwr = (k == KSw);
            end else begin
                r.st = 3'd4; r.rfwr = 1'b1;
                r.gprsel = (k == KOri || k == KLui) ? 2'b01 : 2'b00;
            end
        end else begin
            r.st = 3'd5; r.rfwr = 1'b1; r.wdsel = 2'b01; r.gprsel = 2'b01;
        end
        return r;
    endfunction

    function automatic logic supported_op(input logic [5:0] o);
        return o inside {6'b000000, 6'b001101, 6'b001111, 6'b100011,
                         6'b101011, 6'b000100, 6'b000010, 6'b000011};
    endfunction

    // Instruction-word fields for a class; non-R classes get random funct bits.
    task automatic encode(input kind_t k, output logic [5:0] o, output logic [5:0] f);
        f = 6'($urandom);
        case (k)
            KAddu: begin o = 6'b000000; f = 6'b100001; end
            KSubu: begin o = 6'b000000; f = 6'b100011; end
            KOri:  o = 6'b001101;
            KLui:  o = 6'b001111;
            KLw:   o = 6'b100011;
            KSw:   o = 6'b101011;
            KBeq:  o = 6'b000100;
            KJ:    o = 6'b000010;
            KJal:  o = 6'b000011;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    o = 6'b000000;
                    while (f == 6'b100001 || f == 6'b100011) f = 6'($urandom);
                end else begin
                    o = 6'($urandom);
                    while (supported_op(o)) o = 6'($urandom);
                end
            end
        endcase
    endtask

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Run one instruction; rst is pulled low during cycle rst_ph (-1: none),
    // which aborts it. Illegal instructions always end with a reset.
    task automatic run_instr(input kind_t k, input logic [5:0] o, input logic [5:0] f,
                             input int rst_ph, input int trap_len);
        int n;
        int rp;
        n  = cpi(k, trap_len);
        rp = (k == KBad && rst_ph < 0) ? n - 1 : rst_ph;
        Op    = o;
        Funct = f;
        for (int ph = 0; ph < n; ph++) begin
            Zero = 1'($urandom);
            rst  = (ph == rp) ? 1'b0 : 1'b1;
            step(model(k, ph, Zero));
            if (ph == rp) break;
        end
        rst = 1'b1;
    endtask

    // Monitor: one expected record per cycle, compared on the falling edge.
    always @(negedge clk) begin
        exp_t a, e;
        n_cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{st: state, pcwr: PCWr, irwr: IRWr, rfwr: RFWr, dmwr: DMWr,
                  extop: EXTOp, aluop: ALUOp, npcop: NPCOp, bsel: BSel,
                  gprsel: GPRSel, wdsel: WDSel, ill: illegal};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL ctrl_outputs cycle %0d: got st=%0d vec=%h, expected st=%0d vec=%h",
                         n_cyc, a.st, a, e.st, e);
            end
        end
    end

    initial begin
        kind_t       k;
        logic [5:0]  o, f;
        int          rp, tl, n;

        // Reset held for two edges with a beq sitting in IR.
        rst = 1'b0; Op = 6'b000100; Funct = 6'd0; Zero = 1'b1;
        @(posedge clk);
        #1;
        step(model(KBeq, 0, 1'b0));
        rst = 1'b1;

        // Directed sequence.
        encode(KBeq, o, f);  run_instr(KBeq, o, f, -1, 0);
        encode(KAddu, o, f); run_instr(KAddu, o, f, -1, 0);
        encode(KLw, o, f);   run_instr(KLw, o, f, -1, 0);
        encode(KSw, o, f);   run_instr(KSw, o, f, -1, 0);
        // beq with forced Zero in EXE
        for (int zz = 0; zz < 2; zz++) begin
            Op = 6'b000100; Funct = 6'd0; rst = 1'b1;
            Zero = 1'b0; step(model(KBeq, 0, 1'b0));
            step(model(KBeq, 1, 1'b0));
            Zero = (zz == 0); step(model(KBeq, 2, Zero));
        end
        encode(KJal, o, f);  run_instr(KJal, o, f, -1, 0);
        run_instr(KBad, 6'b111111, 6'd0, -1, 10);
        encode(KLw, o, f);   run_instr(KLw, o, f, 3, 0);
        encode(KSubu, o, f); run_instr(KSubu, o, f, -1, 0);

        // Random instruction stream with occasional mid-instruction resets.
        for (int i = 0; i < 300; i++) begin
            k = kind_t'($urandom_range(0, 9));
            if (k == KBad && $urandom_range(0, 2) != 0) k = kind_t'($urandom_range(0, 8));
            tl = $urandom_range(1, 4);
            n  = cpi(k, tl);
            rp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            encode(k, o, f);
            run_instr(k, o, f, rp, tl);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
